// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: matrix row/column lines and the key code output.
// The master side is the scanner, the slave side is the keypad and its consumer.
interface keypad_scanner_if;
   logic [3:0] col;
   logic [3:0] row;
   logic [3:0] key;
   logic       key_valid;
   logic       pressed;

   modport master (
      input  col,
      output row,
      output key,
      output key_valid,
      output pressed
   );

   modport slave (
      output col,
      input  row,
      input  key,
      input  key_valid,
      input  pressed
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with press/release debounce and a single tracked key.
// Optional auto-repeat of key_valid while held: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
   parameter int SCAN_CYCLES     = 48000,
   parameter int DEBOUNCE_CYCLES = 960000,
   parameter int REPEAT_CYCLES   = 24000000
) (
   input  logic               int_osc,
   input  logic               reset,
   keypad_scanner_if.master   kp
);

   localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] SCAN     = 2'd0;
   localparam logic [1:0] PRESS_DB = 2'd1;
   localparam logic [1:0] HELD     = 2'd2;
   localparam logic [1:0] REL_DB   = 2'd3;

   logic [3:0]    col_q1;
   logic [3:0]    col_s;
   logic [1:0]    state;
   logic [SW-1:0] dwell;
   logic [DW-1:0] db;
   logic [3:0]    row_r;
   logic [1:0]    row_idx;
   logic [1:0]    cap_col;
   logic [1:0]    low_col;
   logic [3:0]    key_r;
   logic          kv;
   logic          hit;
   logic          rpt_fire;

   function automatic logic [3:0] key_map(
      input logic [1:0] r,
      input logic [1:0] c
   );
      logic [3:0] code;
      case ({r, c})
         4'h0: code = 4'h1;
         4'h1: code = 4'h2;
         4'h2: code = 4'h3;
         4'h3: code = 4'hA;
         4'h4: code = 4'h4;
         4'h5: code = 4'h5;
         4'h6: code = 4'h6;
         4'h7: code = 4'hB;
         4'h8: code = 4'h7;
         4'h9: code = 4'h8;
         4'hA: code = 4'h9;
         4'hB: code = 4'hC;
         4'hC: code = 4'hE;
         4'hD: code = 4'h0;
         4'hE: code = 4'hF;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   // Two-flop synchronizer for the asynchronous column inputs.
   always_ff @(posedge int_osc or negedge reset) begin
      if (!reset) begin
         col_q1 <= 4'b0000;
         col_s  <= 4'b0000;
      end else begin
         col_q1 <= kp.col;
         col_s  <= col_q1;
      end
   end

   // Lowest closed column on the currently driven row.
   always_comb begin
      low_col = 2'd0;
      if (col_s[0])      low_col = 2'd0;
      else if (col_s[1]) low_col = 2'd1;
      else if (col_s[2]) low_col = 2'd2;
      else if (col_s[3]) low_col = 2'd3;
   end

   assign hit = col_s[cap_col];

`ifdef KEYPAD_REPEAT_EN
   localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rpt;

   // Repeat period counter; held at zero outside HELD so every entry restarts it.
   always_ff @(posedge int_osc or negedge reset) begin
      if (!reset) begin
         rpt <= '0;
      end else if (state != HELD || !hit) begin
         rpt <= '0;
      end else if (rpt == RPT_LAST) begin
         rpt <= '0;
      end else begin
         rpt <= rpt + RW'(1);
      end
   end

   assign rpt_fire = (state == HELD) && hit && (rpt == RPT_LAST);
`else
   assign rpt_fire = 1'b0;
`endif

   // Scan / debounce state machine and registered outputs.
   always_ff @(posedge int_osc or negedge reset) begin
      if (!reset) begin
         state   <= SCAN;
         dwell   <= '0;
         db      <= '0;
         row_r   <= 4'b0001;
         row_idx <= 2'd0;
         cap_col <= 2'd0;
         key_r   <= 4'h0;
         kv      <= 1'b0;
      end else begin
         kv <= 1'b0;
         unique case (state)
            SCAN: begin
               if (dwell != SCAN_LAST) begin
                  dwell <= dwell + SW'(1);
               end else if (col_s != 4'b0000) begin
                  cap_col <= low_col;
                  db      <= '0;
                  dwell   <= '0;
                  state   <= PRESS_DB;
               end else begin
                  dwell   <= '0;
                  row_r   <= {row_r[2:0], row_r[3]};
                  row_idx <= row_idx + 2'd1;
               end
            end
            PRESS_DB: begin
               if (!hit) begin
                  dwell   <= '0;
                  row_r   <= {row_r[2:0], row_r[3]};
                  row_idx <= row_idx + 2'd1;
                  state   <= SCAN;
               end else if (db == DB_LAST) begin
                  key_r <= key_map(row_idx, cap_col);
                  kv    <= 1'b1;
                  state <= HELD;
               end else begin
                  db <= db + DW'(1);
               end
            end
            HELD: begin
               if (!hit) begin
                  db    <= '0;
                  state <= REL_DB;
               end else if (rpt_fire) begin
                  kv <= 1'b1;
               end
            end
            REL_DB: begin
               if (hit) begin
                  state <= HELD;
               end else if (db == DB_LAST) begin
                  dwell   <= '0;
                  row_r   <= {row_r[2:0], row_r[3]};
                  row_idx <= row_idx + 2'd1;
                  state   <= SCAN;
               end else begin
                  db <= db + DW'(1);
               end
            end
            default: begin
               state <= SCAN;
            end
         endcase
      end
   end

   assign kp.row       = row_r;
   assign kp.key       = key_r;
   assign kp.key_valid = kv;
   assign kp.pressed   = (state == HELD) || (state == REL_DB);

endmodule
